uartrx_addrmap: RTL

CSR block for the UART RX side of the debug UART IP, the counterpart of the UART TX address map.
- Sits between the CPU-side addressing interface and the UART RX core.
- Drives RX enable and RX reset to the core.
- Buffers received bytes in a small synchronous FIFO.
- Exposes data, fill level, status and a sticky overflow flag to software.

---
 rtl/uartrx_pkg.sv | 25 ++
 rtl/uartrx_fifo.sv | 54 +++++
 rtl/uartrx_addrmap.sv | 133 +++++++++++++
 3 files changed

// File: rtl/uartrx_pkg.sv
// Shared definitions for the UART RX address map: CSR word indices,
// register bit positions and the control register layout.
package uartrx_pkg;

  localparam logic [3:0] CSR0_CONTROL = 4'h0;
  localparam logic [3:0] CSR1_RXDATA  = 4'h1;
  localparam logic [3:0] CSR2_STATUS  = 4'h2;

  localparam int CTRL_RX_EN_BIT  = 0;
  localparam int CTRL_RX_RST_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;

  localparam int STAT_AVAIL_BIT    = 0;
  localparam int STAT_FULL_BIT     = 1;
  localparam int STAT_OVF_BIT      = 2;
  localparam int STAT_RX_STATE_BIT = 8;
  localparam int STAT_FILL_LSB     = 16;

  typedef struct packed {
    logic irq_en;
    logic rx_rst;
    logic rx_en;
  } ctrl_t;

endpackage

// File: rtl/uartrx_fifo.sv
// Small synchronous byte FIFO with synchronous flush; pop and push may
// happen on the same edge, so a full FIFO can still take a byte if it pops.
module uartrx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_pop;
  logic          do_push;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  // Flush wins over everything so the FIFO stays empty while it is held.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uartrx_addrmap.sv
// CSR block for the UART RX side: control, pop-on-read data and status.
// Optional interrupt output is enabled by defining UARTRX_IRQ_EN.
module uartrx_addrmap
  import uartrx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_en,
  input  logic        i_wen,
  input  logic [3:0]  i_byteen,
  input  logic [5:0]  i_addr,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_rx_en,
  output logic        o_rx_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_data_valid,
  output logic        o_rx_data_ready,
  input  logic        i_rx_state
`ifdef UARTRX_IRQ_EN
  ,
  output logic        o_irq
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ctrl_t          ctrl_q;
  logic           overflow_q;
  logic [3:0]     word;
  logic           rd_en;
  logic           wr_en;
  logic           pop;
  logic           ovf_set;
  logic           ovf_clr;
  logic [7:0]     fifo_head;
  logic [CW-1:0]  fifo_count;
  logic           fifo_full;
  logic           fifo_empty;
  logic [4:0]     count_ext;
  logic [3:0]     fill;
  logic [31:0]    rd_mux;
  logic           unused_bits;

  assign word  = i_addr[5:2];
  assign rd_en = i_en & ~i_wen;
  assign wr_en = i_en & i_wen;
  assign pop   = rd_en & (word == CSR1_RXDATA);

  assign unused_bits = ^{i_byteen[3:1], i_addr[1:0], i_data[31:3]};

  uartrx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (ctrl_q.rx_rst),
    .push      (i_rx_data_valid),
    .push_data (i_rx_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ctrl_q <= '0;
    end else if (wr_en && word == CSR0_CONTROL && i_byteen[0]) begin
      ctrl_q.rx_en  <= i_data[CTRL_RX_EN_BIT];
      ctrl_q.rx_rst <= i_data[CTRL_RX_RST_BIT];
`ifdef UARTRX_IRQ_EN
      ctrl_q.irq_en <= i_data[CTRL_IRQ_EN_BIT];
`else
      ctrl_q.irq_en <= 1'b0;
`endif
    end
  end

  // A full FIFO only drops a byte when no pop frees a slot on that edge.
  assign ovf_set = i_rx_data_valid & fifo_full & ~pop;
  assign ovf_clr = wr_en & (word == CSR2_STATUS) & i_byteen[0] & i_data[STAT_OVF_BIT];

  always_ff @(posedge clk) begin
    if (!rstn || ctrl_q.rx_rst) overflow_q <= 1'b0;
    else if (ovf_set)           overflow_q <= 1'b1;
    else if (ovf_clr)           overflow_q <= 1'b0;
  end

  // Fill field is 4 bits wide; a full 16-deep FIFO reports 15.
  assign count_ext = 5'(fifo_count);
  assign fill      = count_ext[4] ? 4'hF : count_ext[3:0];

  always_comb begin
    rd_mux = '0;
    case (word)
      CSR0_CONTROL: begin
        rd_mux[CTRL_RX_EN_BIT]  = ctrl_q.rx_en;
        rd_mux[CTRL_RX_RST_BIT] = ctrl_q.rx_rst;
        rd_mux[CTRL_IRQ_EN_BIT] = ctrl_q.irq_en;
      end
      CSR1_RXDATA: begin
        if (!fifo_empty) rd_mux[7:0] = fifo_head;
      end
      CSR2_STATUS: begin
        rd_mux[STAT_AVAIL_BIT]        = ~fifo_empty;
        rd_mux[STAT_FULL_BIT]         = fifo_full;
        rd_mux[STAT_OVF_BIT]          = overflow_q;
        rd_mux[STAT_RX_STATE_BIT]     = i_rx_state;
        rd_mux[STAT_FILL_LSB +: 4]    = fill;
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn)      o_data <= '0;
    else if (rd_en) o_data <= rd_mux;
  end

  assign o_rx_en         = ctrl_q.rx_en;
  assign o_rx_rst        = ctrl_q.rx_rst;
  assign o_rx_data_ready = ~fifo_full;

`ifdef UARTRX_IRQ_EN
  always_ff @(posedge clk) begin
    if (!rstn) o_irq <= 1'b0;
    else       o_irq <= ctrl_q.irq_en & (~fifo_empty | overflow_q);
  end
`endif

endmodule
